// File: rtl/mem_2ps_be.sv
// ---------------------------------------------------------------------------
// mem_2ps_be
//   Simple dual-port RAM: one write port with per-byte enables, one gated read
//   port with a valid strobe, selectable read latency (1 or 2 cycles),
//   selectable read-during-write behaviour and an optional zero-fill sequence
//   that runs after reset so buffers start from known-zero contents.
//
// Parameters
//   ADDR_WIDTH     address bits, MEM_DEPTH = 2**ADDR_WIDTH
//   DATA_WIDTH     word width, multiple of 8 (NB = DATA_WIDTH/8 byte lanes)
//   OUT_REG        0: read latency 1, 1: extra output register, latency 2
//   RDW_MODE       same-address read+write: 0 old word, 1 merged new word
//   CLEAR_ON_RESET 1: zero every word after reset, 0: no clear sequence
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   init_busy_o   high while the clear sequence runs (ports ignored)
//   write_en_i    write request
//   addr_write_i  write address
//   data_write_i  write data
//   byte_en_i     lane k enables bits [8k+7:8k]
//   read_en_i     read request
//   addr_read_i   read address
//   data_read_o   read data, holds between reads
//   data_valid_o  one-cycle strobe per accepted read, aligned with data
// ---------------------------------------------------------------------------
module mem_2ps_be #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy_o,
  input  logic                    write_en_i,
  input  logic [ADDR_WIDTH-1:0]   addr_write_i,
  input  logic [DATA_WIDTH-1:0]   data_write_i,
  input  logic [DATA_WIDTH/8-1:0] byte_en_i,
  input  logic                    read_en_i,
  input  logic [ADDR_WIDTH-1:0]   addr_read_i,
  output logic [DATA_WIDTH-1:0]   data_read_o,
  output logic                    data_valid_o
);

  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB        = DATA_WIDTH / 8;

  // Replace the enabled lanes of old_w with the matching lanes of new_w.
  function automatic logic [DATA_WIDTH-1:0] f_merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] w_clr_cnt;
  logic                  w_clr_we;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_rdw_hit;
  logic [DATA_WIDTH-1:0] w_mem_rd;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Clear sequencer: CLEAR walks every address once, then READY.
  generate
    if (CLEAR_ON_RESET != 0) begin : g_clear
      localparam logic ST_CLEAR = 1'b0;
      localparam logic ST_READY = 1'b1;
      localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

      logic                  r_state;
      logic [ADDR_WIDTH-1:0] r_clr_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state   <= ST_CLEAR;
          r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_ADDR) r_state <= ST_READY;
        end
      end

      assign w_busy    = (r_state == ST_CLEAR);
      assign w_clr_cnt = r_clr_cnt;
    end else begin : g_no_clear
      assign w_busy    = 1'b0;
      assign w_clr_cnt = '0;
    end
  endgenerate

  assign init_busy_o = w_busy;

  // User ports are honoured only when ready and out of reset.
  assign w_clr_we = w_busy & ~rst;
  assign w_wr_acc = write_en_i & ~w_busy & ~rst;
  assign w_rd_acc = read_en_i  & ~w_busy & ~rst;

  // Memory write: the clear sequence owns the port while it runs.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (byte_en_i[k]) r_mem[addr_write_i][8*k +: 8] <= data_write_i[8*k +: 8];
      end
    end
  end

  // The array read sees the pre-write word; the merged word is forwarded
  // only when write-first behaviour is selected.
  assign w_mem_rd  = r_mem[addr_read_i];
  assign w_rdw_hit = w_wr_acc & (addr_write_i == addr_read_i) & (|byte_en_i);
  assign w_rd_word = ((RDW_MODE != 0) && w_rdw_hit)
                   ? f_merge_lanes(w_mem_rd, data_write_i, byte_en_i)
                   : w_mem_rd;

  // ---- stage p0: read capture ----
  logic [DATA_WIDTH-1:0] r_rd_data_p0;
  logic                  r_rd_vld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld_p0  <= 1'b0;
      r_rd_data_p0 <= '0;
    end else begin
      r_rd_vld_p0 <= w_rd_acc;
      if (w_rd_acc) r_rd_data_p0 <= w_rd_word;
    end
  end

  // ---- stage p1: optional output register ----
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_rd_data_p1;
      logic                  r_rd_vld_p1;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_vld_p1  <= 1'b0;
          r_rd_data_p1 <= '0;
        end else begin
          r_rd_vld_p1 <= r_rd_vld_p0;
          if (r_rd_vld_p0) r_rd_data_p1 <= r_rd_data_p0;
        end
      end

      assign data_read_o  = r_rd_data_p1;
      assign data_valid_o = r_rd_vld_p1;
    end else begin : g_no_out_reg
      assign data_read_o  = r_rd_data_p0;
      assign data_valid_o = r_rd_vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_2ps_be.sv
// Bench for mem_2ps_be. Three instances, all 32-bit wide, 16 words:
//   u0: latency 1, old-word RDW, clear on reset
//   u1: latency 2, merged-word RDW, clear on reset
//   u2: latency 1, no clear (own stimulus)
// Expected read words are queued when a read is issued; monitors pop them
// whenever data_valid_o is high.
module tb_mem_2ps_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for u0/u1
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [3:0]  wa = '0, ra = '0;
  logic [31:0] wd = '0;
  logic [3:0]  be = '0;
  // stimulus for u2
  logic        rst2 = 1'b1;
  logic        we2 = 1'b0, re2 = 1'b0;
  logic [3:0]  wa2 = '0, ra2 = '0;
  logic [31:0] wd2 = '0;
  logic [3:0]  be2 = '0;

  logic        busy0, busy1, busy2;
  logic [31:0] dr0, dr1, dr2;
  logic        dv0, dv1, dv2;

  mem_2ps_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .init_busy_o(busy0), .write_en_i(we), .addr_write_i(wa),
    .data_write_i(wd), .byte_en_i(be), .read_en_i(re), .addr_read_i(ra),
    .data_read_o(dr0), .data_valid_o(dv0));

  mem_2ps_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .init_busy_o(busy1), .write_en_i(we), .addr_write_i(wa),
    .data_write_i(wd), .byte_en_i(be), .read_en_i(re), .addr_read_i(ra),
    .data_read_o(dr1), .data_valid_o(dv1));

  mem_2ps_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .rst(rst2), .init_busy_o(busy2), .write_en_i(we2), .addr_write_i(wa2),
    .data_write_i(wd2), .byte_en_i(be2), .read_en_i(re2), .addr_read_i(ra2),
    .data_read_o(dr2), .data_valid_o(dv2));

  int checks = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1; wa = a; wd = d; be = m;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
    re = 1'b1; ra = a;
    q0.push_back(e0);
    q1.push_back(e1);
    tick();
    re = 1'b0;
  endtask

  // Count cycles with init_busy_o high from rst release, bounded.
  task automatic wait_clear(output int n);
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      tick();
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (dv0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL u0_unexpected_valid actual=%h required=no_valid", dr0);
      end else chk("u0_read", dr0, q0.pop_front());
    end
    if (dv1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_unexpected_valid actual=%h required=no_valid", dr1);
      end else chk("u1_read", dr1, q1.pop_front());
    end
    if (dv2) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL u2_unexpected_valid actual=%h required=no_valid", dr2);
      end else chk("u2_read", dr2, q2.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    tick(); tick();
    chk("rst_busy0", 32'(busy0), 32'd1);
    chk("rst_busy1", 32'(busy1), 32'd1);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_dv0", 32'(dv0), 32'd0);
    chk("rst_dv1", 32'(dv1), 32'd0);
    chk("rst_dr0", dr0, 32'h0);
    chk("rst_dr1", dr1, 32'h0);
    chk("rst_dr2", dr2, 32'h0);

    // clear: 16 busy cycles; a write and reads during busy are ignored
    rst = 1'b0;
    we = 1'b1; wa = 4'd3; wd = 32'hDEADBEEF; be = 4'hF;
    re = 1'b1; ra = 4'd0;
    wait_clear(n);
    we = 1'b0; re = 1'b0;
    chk("clear_len", 32'(n), 32'd16);
    chk("clear_done_u1", 32'(busy1), 32'd0);
    for (int a = 0; a < 16; a++) rd(4'(a), 32'h0, 32'h0);
    tick(); tick(); tick();

    // reset at clear counter 7 restarts the sequence
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (7) tick();
    chk("midclear_busy", 32'(busy0), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    wait_clear(n);
    chk("restart_len", 32'(n), 32'd16);

    // byte enables
    wr(4'd5, 32'hAABBCCDD, 4'hF);
    wr(4'd5, 32'h11223344, 4'h5);
    wr(4'd5, 32'h99999999, 4'h0);
    rd(4'd5, 32'hAA22CC44, 32'hAA22CC44);
    tick(); tick();

    // latency and back-to-back reads
    for (int a = 0; a < 8; a++) wr(4'(a), 32'h10 + 32'(a), 4'hF);
    for (int i = 0; i < 8; i++) begin
      re = 1'b1; ra = 4'(i);
      q0.push_back(32'h10 + 32'(i));
      q1.push_back(32'h10 + 32'(i));
      tick();
      chk("lat1_vld", 32'(dv0), 32'd1);
      chk("lat1_data", dr0, 32'h10 + 32'(i));
      if (i == 0) chk("lat2_first_vld", 32'(dv1), 32'd0);
      else begin
        chk("lat2_vld", 32'(dv1), 32'd1);
        chk("lat2_data", dr1, 32'h10 + 32'(i) - 32'd1);
      end
    end
    re = 1'b0;
    tick();
    chk("lat1_end_vld", 32'(dv0), 32'd0);
    chk("lat1_hold", dr0, 32'h17);
    chk("lat2_last_vld", 32'(dv1), 32'd1);
    chk("lat2_last", dr1, 32'h17);
    tick();
    chk("lat2_end_vld", 32'(dv1), 32'd0);
    chk("lat2_hold", dr1, 32'h17);

    // read-during-write
    wr(4'd2, 32'h55, 4'hF);
    we = 1'b1; wa = 4'd2; wd = 32'hA0; be = 4'h1;
    re = 1'b1; ra = 4'd2;
    q0.push_back(32'h55);
    q1.push_back(32'hA0);
    tick();
    we = 1'b0; re = 1'b0;
    rd(4'd2, 32'hA0, 32'hA0);
    // different addresses do not interact
    we = 1'b1; wa = 4'd6; wd = 32'h12345678; be = 4'hF;
    re = 1'b1; ra = 4'd7;
    q0.push_back(32'h17);
    q1.push_back(32'h17);
    tick();
    we = 1'b0; re = 1'b0;
    rd(4'd6, 32'h12345678, 32'h12345678);
    tick(); tick(); tick();

    // reset with a read in flight (u1 still has it in its output stage)
    re = 1'b1; ra = 4'd5;
    q0.push_back(32'h15);
    tick();
    re = 1'b0; rst = 1'b1;
    tick();
    chk("kill_vld1", 32'(dv1), 32'd0);
    chk("kill_dr1", dr1, 32'h0);
    chk("kill_dr0", dr0, 32'h0);
    tick();
    chk("kill_vld1_later", 32'(dv1), 32'd0);
    rst = 1'b0;
    wait_clear(n);
    chk("reclear_len", 32'(n), 32'd16);
    rd(4'd5, 32'h0, 32'h0);
    tick(); tick();

    // no-clear instance: ready immediately after reset
    rst2 = 1'b0;
    we2 = 1'b1; wa2 = 4'd9; wd2 = 32'hCAFEF00D; be2 = 4'hF;
    tick();
    we2 = 1'b0;
    chk("noclr_busy", 32'(busy2), 32'd0);
    re2 = 1'b1; ra2 = 4'd9;
    q2.push_back(32'hCAFEF00D);
    tick();
    re2 = 1'b0;
    chk("noclr_data", dr2, 32'hCAFEF00D);
    we2 = 1'b1; wa2 = 4'd9; wd2 = 32'h0000AB00; be2 = 4'h2;
    tick();
    we2 = 1'b0;
    re2 = 1'b1; ra2 = 4'd9;
    q2.push_back(32'hCAFEAB0D);
    tick();
    re2 = 1'b0;
    chk("noclr_busy_end", 32'(busy2), 32'd0);

    repeat (4) tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
